// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with byte enables, read-valid strobes, selectable RDW mode and
// same-address collision arbitration/counting. Define DPRAM_OUT_REG_EN for a second output stage.
module dual_port_ram_be #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned A_PRIORITY = 1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [WORD_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [WORD_WIDTH-1:0]   wdata_a,
  output logic [WORD_WIDTH-1:0]   rdata_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [WORD_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [WORD_WIDTH-1:0]   wdata_b,
  output logic [WORD_WIDTH-1:0]   rdata_b,
  output logic                    rvalid_b,
  input  logic                    coll_clr,
  output logic                    coll_flag,
  output logic [CNT_WIDTH-1:0]    coll_cnt
);
  localparam int unsigned NB    = WORD_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic        A_WINS = (A_PRIORITY != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (WORD_WIDTH % 8 != 0) begin : g_width_check
    $error("WORD_WIDTH must be a multiple of 8");
  end

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a, wr_b, same_addr, collision;
  logic [NB-1:0]         keep_a, keep_b;
  logic [WORD_WIDTH-1:0] rd_next_a, rd_next_b;
  logic [WORD_WIDTH-1:0] rd1_a, rd1_b;
  logic                  rv1_a, rv1_b;

  function automatic logic [WORD_WIDTH-1:0] merge_bytes(
    input logic [WORD_WIDTH-1:0] old_word,
    input logic [WORD_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be
  );
    logic [WORD_WIDTH-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // A write with no byte enabled is treated as a plain read everywhere (no change, no collision).
  assign wr_a      = en_a & we_a & (|be_a);
  assign wr_b      = en_b & we_b & (|be_b);
  assign same_addr = (addr_a == addr_b);
  assign collision = en_a & en_b & same_addr & (wr_a | wr_b);

  // Per-byte arbitration: only the losing port's lanes that clash with the winner are suppressed.
  always_comb begin
    keep_a = '0;
    keep_b = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      keep_a[i] = wr_a & be_a[i] & ~(same_addr & wr_b & be_b[i] & ~A_WINS);
      keep_b[i] = wr_b & be_b[i] & ~(same_addr & wr_a & be_a[i] &  A_WINS);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (keep_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      if (keep_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
  end

  always_comb begin
    rd_next_a = mem[addr_a];
    rd_next_b = mem[addr_b];
    if (RDW_MODE == 0) begin
      if (we_a) rd_next_a = merge_bytes(mem[addr_a], wdata_a, be_a);
      if (we_b) rd_next_b = merge_bytes(mem[addr_b], wdata_b, be_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_a <= '0;
      rd1_b <= '0;
      rv1_a <= 1'b0;
      rv1_b <= 1'b0;
    end else begin
      rv1_a <= en_a;
      rv1_b <= en_b;
      if (en_a) rd1_a <= rd_next_a;
      if (en_b) rd1_b <= rd_next_b;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [WORD_WIDTH-1:0] rd2_a, rd2_b;
  logic                  rv2_a, rv2_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd2_a <= '0;
      rd2_b <= '0;
      rv2_a <= 1'b0;
      rv2_b <= 1'b0;
    end else begin
      rv2_a <= rv1_a;
      rv2_b <= rv1_b;
      if (rv1_a) rd2_a <= rd1_a;
      if (rv1_b) rd2_b <= rd1_b;
    end
  end

  assign rdata_a  = rd2_a;
  assign rdata_b  = rd2_b;
  assign rvalid_a = rv2_a;
  assign rvalid_b = rv2_b;
`else
  assign rdata_a  = rd1_a;
  assign rdata_b  = rd1_b;
  assign rvalid_a = rv1_a;
  assign rvalid_b = rv1_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_flag <= 1'b0;
      coll_cnt  <= '0;
    end else if (coll_clr) begin
      coll_flag <= 1'b0;
      coll_cnt  <= '0;
    end else if (collision) begin
      coll_flag <= 1'b1;
      if (coll_cnt != CNT_MAX) coll_cnt <= coll_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Testbench for dual_port_ram_be: directed vector table plus randomized traffic against a
// word-level reference model of the memory, collision counter and read pipeline.
module tb_dual_port_ram_be;
  localparam int unsigned WW   = 16;
  localparam int unsigned AW   = 9;
  localparam int unsigned RDW  = 0;
  localparam int unsigned APRI = 1;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en_a = 0, we_a = 0, en_b = 0, we_b = 0, coll_clr = 0;
  logic [1:0]    be_a = '0, be_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [WW-1:0] wdata_a = '0, wdata_b = '0;
  logic [WW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, coll_flag;
  logic [CW-1:0] coll_cnt;

  dual_port_ram_be #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .RDW_MODE(RDW), .A_PRIORITY(APRI), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .coll_clr(coll_clr), .coll_flag(coll_flag), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en_a; logic we_a; logic [1:0] be_a; logic [AW-1:0] addr_a; logic [WW-1:0] wdata_a;
    logic en_b; logic we_b; logic [1:0] be_b; logic [AW-1:0] addr_b; logic [WW-1:0] wdata_b;
    logic clr;
    logic chk_a; logic [WW-1:0] exp_a;
    logic chk_b; logic [WW-1:0] exp_b;
    int exp_cnt; logic exp_flag;
  } vec_t;

  vec_t tbl [18];
  vec_t idle;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WW-1:0] ref_mem [2**AW];
  logic          pv_a [LAT], pv_b [LAT];
  logic [WW-1:0] pd_a [LAT], pd_b [LAT];
  logic [WW-1:0] m_rd_a, m_rd_b;
  logic          m_rv_a, m_rv_b, m_flag;
  int            m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] put_bytes(input logic [WW-1:0] w, input logic [WW-1:0] d,
                                              input logic [1:0] be);
    logic [WW-1:0] r;
    r = w;
    for (int k = 0; k < 2; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LAT; i++) begin
      pv_a[i] = 0; pv_b[i] = 0; pd_a[i] = '0; pd_b[i] = '0;
    end
    m_rd_a = '0; m_rd_b = '0; m_rv_a = 0; m_rv_b = 0; m_flag = 0; m_cnt = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rdata_a"},  rdata_a,  m_rd_a);
    check({tag, ".rvalid_a"}, rvalid_a, m_rv_a);
    check({tag, ".rdata_b"},  rdata_b,  m_rd_b);
    check({tag, ".rvalid_b"}, rvalid_b, m_rv_b);
    check({tag, ".coll_cnt"}, coll_cnt, m_cnt);
    check({tag, ".coll_flag"}, coll_flag, m_flag);
  endtask

  task automatic drive(input vec_t v);
    en_a = v.en_a; we_a = v.we_a; be_a = v.be_a; addr_a = v.addr_a; wdata_a = v.wdata_a;
    en_b = v.en_b; we_b = v.we_b; be_b = v.be_b; addr_b = v.addr_b; wdata_b = v.wdata_b;
    coll_clr = v.clr;
  endtask

  // One clock: update the model from the driven inputs, then compare 1 time unit after the edge.
  task automatic step(input string tag);
    logic [WW-1:0] oa, ob, ra, rb, w;
    logic wa, wb, coll;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      oa = ref_mem[addr_a];
      ob = ref_mem[addr_b];
      ra = (RDW == 0 && we_a) ? put_bytes(oa, wdata_a, be_a) : oa;
      rb = (RDW == 0 && we_b) ? put_bytes(ob, wdata_b, be_b) : ob;
      wa = en_a && we_a && (be_a != 0);
      wb = en_b && we_b && (be_b != 0);
      coll = en_a && en_b && (addr_a == addr_b) && (wa || wb);
      if (wa && wb && addr_a == addr_b) begin
        w = oa;
        for (int k = 0; k < 2; k++) begin
          if (APRI != 0) begin
            if (be_a[k]) w[8*k +: 8] = wdata_a[8*k +: 8];
            else if (be_b[k]) w[8*k +: 8] = wdata_b[8*k +: 8];
          end else begin
            if (be_b[k]) w[8*k +: 8] = wdata_b[8*k +: 8];
            else if (be_a[k]) w[8*k +: 8] = wdata_a[8*k +: 8];
          end
        end
        ref_mem[addr_a] = w;
      end else begin
        if (wa) ref_mem[addr_a] = put_bytes(ref_mem[addr_a], wdata_a, be_a);
        if (wb) ref_mem[addr_b] = put_bytes(ref_mem[addr_b], wdata_b, be_b);
      end
      if (coll_clr) begin
        m_cnt = 0; m_flag = 0;
      end else if (coll) begin
        m_flag = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        pv_a[i] = pv_a[i-1]; pd_a[i] = pd_a[i-1];
        pv_b[i] = pv_b[i-1]; pd_b[i] = pd_b[i-1];
      end
      pv_a[0] = en_a; pd_a[0] = ra;
      pv_b[0] = en_b; pd_b[0] = rb;
      m_rv_a = pv_a[LAT-1];
      m_rv_b = pv_b[LAT-1];
      if (m_rv_a) m_rd_a = pd_a[LAT-1];
      if (m_rv_b) m_rd_b = pd_b[LAT-1];
    end
    #1;
    compare_all(tag);
  endtask

  function automatic vec_t mk(
    input logic ea, input logic wea, input logic [1:0] bea, input logic [AW-1:0] aa, input logic [WW-1:0] da,
    input logic eb, input logic web, input logic [1:0] beb, input logic [AW-1:0] ab, input logic [WW-1:0] db,
    input logic clr, input logic ca, input logic [WW-1:0] xa, input logic cb, input logic [WW-1:0] xb,
    input int cnt, input logic flag);
    vec_t v;
    v.en_a = ea; v.we_a = wea; v.be_a = bea; v.addr_a = aa; v.wdata_a = da;
    v.en_b = eb; v.we_b = web; v.be_b = beb; v.addr_b = ab; v.wdata_b = db;
    v.clr = clr; v.chk_a = ca; v.exp_a = xa; v.chk_b = cb; v.exp_b = xb;
    v.exp_cnt = cnt; v.exp_flag = flag;
    return v;
  endfunction

  initial begin
    vec_t r;
    idle = mk(0,0,2'b00,'0,'0, 0,0,2'b00,'0,'0, 0, 0,'0, 0,'0, 0,0);
    //           A: en we be   addr    wdata     B: en we be   addr    wdata   clr chkA expA chkB expB cnt flag
    tbl[0]  = mk(1,1,2'b11,9'h010,16'hFFFF, 0,0,2'b00,9'h000,16'h0000, 0, 0,'0, 0,'0,             0,0);
    tbl[1]  = mk(1,1,2'b01,9'h010,16'h1234, 0,0,2'b00,9'h000,16'h0000, 0, 0,'0, 0,'0,             0,0);
    tbl[2]  = mk(0,0,2'b00,9'h000,16'h0000, 1,0,2'b00,9'h010,16'h0000, 0, 0,'0, 1,16'hFF34,       0,0);
    tbl[3]  = mk(1,1,2'b11,9'h020,16'hAAAA, 0,0,2'b00,9'h000,16'h0000, 0, 0,'0, 0,'0,             0,0);
    tbl[4]  = mk(1,1,2'b11,9'h020,16'h5555, 0,0,2'b00,9'h000,16'h0000, 0,
                 1,(RDW == 0) ? 16'h5555 : 16'hAAAA, 0,'0,                                        0,0);
    tbl[5]  = mk(1,1,2'b11,9'h030,16'h1111, 1,1,2'b11,9'h030,16'h2222, 0, 0,'0, 0,'0,             1,1);
    tbl[6]  = mk(1,0,2'b00,9'h030,16'h0000, 0,0,2'b00,9'h000,16'h0000, 0, 1,16'h1111, 0,'0,       1,1);
    tbl[7]  = mk(1,1,2'b01,9'h030,16'h1111, 1,1,2'b10,9'h030,16'h2222, 0, 0,'0, 0,'0,             2,1);
    tbl[8]  = mk(0,0,2'b00,9'h000,16'h0000, 1,0,2'b00,9'h030,16'h0000, 0, 0,'0, 1,16'h2211,       2,1);
    tbl[9]  = mk(1,1,2'b11,9'h040,16'h0F0F, 0,0,2'b00,9'h000,16'h0000, 0, 0,'0, 0,'0,             2,1);
    tbl[10] = mk(1,1,2'b11,9'h040,16'hF0F0, 1,0,2'b00,9'h040,16'h0000, 0, 0,'0, 1,16'h0F0F,       3,1);
    tbl[11] = mk(0,0,2'b00,9'h000,16'h0000, 1,0,2'b00,9'h040,16'h0000, 0, 0,'0, 1,16'hF0F0,       3,1);
    tbl[12] = mk(1,1,2'b11,9'h050,16'h0001, 1,0,2'b00,9'h050,16'h0000, 0, 0,'0, 0,'0,             3,1);
    tbl[13] = mk(1,1,2'b11,9'h050,16'h0002, 1,0,2'b00,9'h050,16'h0000, 0, 0,'0, 1,16'h0001,       3,1);
    tbl[14] = mk(1,1,2'b11,9'h050,16'hABCD, 1,1,2'b11,9'h050,16'h9999, 1, 0,'0, 0,'0,             0,0);
    tbl[15] = mk(0,0,2'b00,9'h000,16'h0000, 1,0,2'b00,9'h050,16'h0000, 0, 0,'0, 1,16'hABCD,       0,0);
    tbl[16] = mk(1,0,2'b00,9'h010,16'h0000, 1,0,2'b00,9'h010,16'h0000, 0, 1,16'hFF34, 1,16'hFF34, 0,0);
    tbl[17] = mk(1,1,2'b11,9'h060,16'h0001, 1,1,2'b11,9'h061,16'h0002, 0, 0,'0, 0,'0,             0,0);

    // Power-on reset: outputs must clear asynchronously, before any clock edge.
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare_all("por");
    step("por_clk");
    step("por_clk");
    rst_n = 1'b1;

    // Fill the whole array so every later read has a known value.
    for (int i = 0; i < 2**AW; i++) begin
      r = idle;
      r.en_a = 1; r.we_a = 1; r.be_a = 2'b11; r.addr_a = i[AW-1:0]; r.wdata_a = $urandom();
      drive(r);
      step("init");
    end
    drive(idle);
    step("init_idle");

    // Directed vectors: applied for one cycle, then idle until the read result emerges.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      step($sformatf("vec%0d", i));
      drive(idle);
      for (int j = 1; j < LAT; j++) step($sformatf("vec%0d_lat", i));
      if (tbl[i].chk_a) begin
        check($sformatf("vec%0d.exp_rdata_a", i), rdata_a, tbl[i].exp_a);
        check($sformatf("vec%0d.exp_rvalid_a", i), rvalid_a, 1);
      end
      if (tbl[i].chk_b) begin
        check($sformatf("vec%0d.exp_rdata_b", i), rdata_b, tbl[i].exp_b);
        check($sformatf("vec%0d.exp_rvalid_b", i), rvalid_b, 1);
      end
      check($sformatf("vec%0d.exp_cnt", i), coll_cnt, tbl[i].exp_cnt);
      check($sformatf("vec%0d.exp_flag", i), coll_flag, tbl[i].exp_flag);
    end

    // Reset mid-traffic: collision first so the counter is non-zero, then reads in flight.
    drive(mk(1,1,2'b11,9'h070,16'h1234, 1,0,2'b00,9'h070,16'h0000, 0, 0,'0, 0,'0, 0,0));
    step("rst_pre_coll");
    drive(mk(1,0,2'b00,9'h010,16'h0000, 1,0,2'b00,9'h030,16'h0000, 0, 0,'0, 0,'0, 0,0));
    step("rst_pre_rd");
    check("rst_pre.cnt_nonzero", coll_cnt, 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1 compare_all("rst_async");
    step("rst_held");
    step("rst_held");
    rst_n = 1'b1;
    drive(idle);
    for (int j = 0; j < LAT + 1; j++) step("rst_no_late");
    drive(mk(1,0,2'b00,9'h010,16'h0000, 0,0,2'b00,9'h000,16'h0000, 0, 0,'0, 0,'0, 0,0));
    step("rst_first_rd");
    drive(idle);
    for (int j = 1; j < LAT; j++) step("rst_first_rd_lat");
    check("rst_first_rd.preserved", rdata_a, 16'hFF34);
    check("rst_first_rd.rvalid", rvalid_a, 1);

    // Randomized traffic concentrated on a few addresses so collisions are frequent.
    for (int i = 0; i < 3000; i++) begin
      r = idle;
      r.en_a = ($urandom_range(3) != 0); r.we_a = $urandom_range(1); r.be_a = $urandom_range(3);
      r.en_b = ($urandom_range(3) != 0); r.we_b = $urandom_range(1); r.be_b = $urandom_range(3);
      r.addr_a = ($urandom_range(3) == 0) ? AW'($urandom()) : AW'($urandom_range(7));
      r.addr_b = ($urandom_range(3) == 0) ? AW'($urandom()) : AW'($urandom_range(7));
      r.wdata_a = $urandom(); r.wdata_b = $urandom();
      r.clr = ($urandom_range(15) == 0);
      drive(r);
      step("rand");
    end
    drive(idle);
    step("rand_tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
